// File: rtl/jam_param.sv
`timescale 1ns/1ps
// jam_param: exhaustive job-assignment solver. It walks every permutation of
// N jobs over N workers in lexicographic order and reads each worker/job cost
// through an external ROM port. It reports the best total (minimum or maximum)
// and how many permutations reach that total.
module jam_param #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 7,
    parameter int SW = 10,
    parameter int MW = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          Start,
    input  logic          Mode,
    input  logic [CW-1:0] Cost,
    output logic [IW-1:0] W,
    output logic [IW-1:0] J,
    output logic          Busy,
    output logic [SW-1:0] MinCost,
    output logic [MW-1:0] MatchCount,
    output logic          Valid
);

    typedef enum logic [1:0] {IDLE, EVAL, UPD, DONE} state_t;

    localparam logic [IW-1:0] W_LAST = IW'(N - 1);

    state_t        state;
    logic          mode_q;   // 0 = minimise, 1 = maximise
    logic          first;    // next UPD scores the first permutation of the run
    logic [SW-1:0] sum;
    logic [IW-1:0] perm [N];

    logic [IW-1:0] nxt [N];  // lexicographic successor of perm
    logic [IW-1:0] swp [N];  // perm after the pivot swap, before the suffix reversal
    logic          last;     // perm is N-1..0, so no successor exists
    logic [IW-1:0] j_next;   // perm[W+1], the job for the next EVAL cycle
    logic          better;
    logic          equal;

    // Successor permutation: find the pivot, swap it with the rightmost larger
    // element, then reverse the suffix. Indices come only from loop variables.
    always_comb begin
        int            piv;
        int            sj;
        logic          found;
        logic [IW-1:0] pv;
        logic [IW-1:0] sv;
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        piv   = 0;
        sj    = 0;
        found = 1'b0;
        pv    = '0;
        sv    = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (perm[i] < perm[i+1]) begin
                found = 1'b1;
                piv   = i;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i == piv) pv = perm[i];
        end
        for (int i = 0; i < N; i++) begin
            if (i > piv && perm[i] > pv) sj = i;
        end
        for (int i = 0; i < N; i++) begin
            if (i == sj) sv = perm[i];
        end
        for (int i = 0; i < N; i++) begin
            swp[i] = (i == piv) ? sv : ((i == sj) ? pv : perm[i]);
        end
        for (int i = 0; i < N; i++) begin
            nxt[i] = swp[i];
            for (int s = 0; s < N; s++) begin
                if (i > piv && s == N + piv - i) nxt[i] = swp[s];
            end
        end
        last = ~found;
    end

    // Job index for the following EVAL cycle, and the scoring comparisons.
    always_comb begin
        j_next = '0;
        for (int i = 0; i < N; i++) begin
            if (i == int'(W) + 1) j_next = perm[i];
        end
        better = first || (mode_q ? (sum > MinCost) : (sum < MinCost));
        equal  = (sum == MinCost);
    end

    // Control FSM with registered outputs, accumulator and permutation register.
    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            W          <= '0;
            J          <= '0;
            Busy       <= 1'b0;
            Valid      <= 1'b0;
            MinCost    <= '1;
            MatchCount <= '0;
            mode_q     <= 1'b0;
            first      <= 1'b0;
            sum        <= '0;
            // NOTE: perm is a handful of flops, not a RAM, so it takes the async reset like any other register.
            for (int i = 0; i < N; i++) perm[i] <= IW'(i);
        end else begin
            case (state)
                IDLE: begin
                    W <= '0;
                    J <= '0;
                    if (Start) begin
                        mode_q     <= Mode;
                        first      <= 1'b1;
                        sum        <= '0;
                        MatchCount <= '0;
                        MinCost    <= '1;
                        Busy       <= 1'b1;
                        for (int i = 0; i < N; i++) perm[i] <= IW'(i);
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    sum <= sum + SW'(Cost);
                    if (W == W_LAST) begin
                        state <= UPD;
                    end else begin
                        W <= W + 1'b1;
                        J <= j_next;
                    end
                end
                UPD: begin
                    if (better) begin
                        MinCost    <= sum;
                        MatchCount <= MW'(1);
                    end else if (equal && (MatchCount != '1)) begin
                        MatchCount <= MatchCount + 1'b1;
                    end
                    first <= 1'b0;
                    sum   <= '0;
                    W     <= '0;
                    if (last) begin
                        J     <= '0;
                        Valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        for (int i = 0; i < N; i++) perm[i] <= nxt[i];
                        J     <= nxt[0];
                        state <= EVAL;
                    end
                end
                DONE: begin
                    Valid <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_param.sv
`timescale 1ns/1ps
// tb_jam_param: directed bench with three solver instances (N=4, N=3, N=6),
// each fed by its own combinational cost table. Expected results are hand-derived.
module tb_jam_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [2:0] start;

    always #5 clk = ~clk;

    logic [2:0] w4, j4, w3, j3, w6, j6;
    logic [6:0] cost4, cost3, cost6;
    logic       busy4, busy3, busy6, valid4, valid3, valid6;
    logic [9:0] min4, min3, min6;
    logic [15:0] cnt4, cnt3, cnt6;

    // Cost tables: N=4 diagonal-zero, N=3 cost=J, N=6 constant maximum.
    always_comb begin
        cost4 = (w4 == j4) ? 7'd0 : 7'd10;
        cost3 = {4'd0, j3};
        cost6 = 7'd127;
    end

    jam_param #(.N(4)) u_n4 (
        .CLK(clk), .RST(rst), .Start(start[0]), .Mode(mode), .Cost(cost4),
        .W(w4), .J(j4), .Busy(busy4), .MinCost(min4), .MatchCount(cnt4), .Valid(valid4)
    );
    jam_param #(.N(3)) u_n3 (
        .CLK(clk), .RST(rst), .Start(start[1]), .Mode(mode), .Cost(cost3),
        .W(w3), .J(j3), .Busy(busy3), .MinCost(min3), .MatchCount(cnt3), .Valid(valid3)
    );
    jam_param #(.N(6)) u_n6 (
        .CLK(clk), .RST(rst), .Start(start[2]), .Mode(mode), .Cost(cost6),
        .W(w6), .J(j6), .Busy(busy6), .MinCost(min6), .MatchCount(cnt6), .Valid(valid6)
    );

    // Select the instance under test.
    int          sel;
    logic [31:0] s_w, s_j, s_busy, s_valid, s_min, s_cnt;
    always_comb begin
        s_w = '0; s_j = '0; s_busy = '0; s_valid = '0; s_min = '0; s_cnt = '0;
        case (sel)
            0: begin s_w = 32'(w4); s_j = 32'(j4); s_busy = 32'(busy4); s_valid = 32'(valid4); s_min = 32'(min4); s_cnt = 32'(cnt4); end
            1: begin s_w = 32'(w3); s_j = 32'(j3); s_busy = 32'(busy3); s_valid = 32'(valid3); s_min = 32'(min3); s_cnt = 32'(cnt3); end
            default: begin s_w = 32'(w6); s_j = 32'(j6); s_busy = 32'(busy6); s_valid = 32'(valid6); s_min = 32'(min6); s_cnt = 32'(cnt6); end
        endcase
    end

    int checks   = 0;
    int failures = 0;
    int wj_log [1:8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One run: Start at edge 0, optional re-Start pulse or mid-run reset, then
    // checks of Valid timing, Busy window and final results.
    task automatic run(input string tag, input int unit, input logic m, input int exp_valid,
                       input int pulse_at, input int rst_at,
                       input logic [31:0] exp_min, input logic [31:0] exp_cnt);
        int   first_v  = 0;
        int   nv       = 0;
        int   busy_bad = 0;
        logic exp_busy;
        sel = unit;
        @(negedge clk);
        mode        = m;
        start[unit] = 1'b1;
        @(posedge clk);
        #1;
        start[unit] = 1'b0;
        mode        = ~m;   // must be ignored while busy
        for (int c = 1; c <= exp_valid + 3; c++) begin
            @(negedge clk);
            if (c <= 8) wj_log[c] = int'({s_w[2:0], s_j[2:0]});
            if (s_valid[0]) begin
                nv++;
                if (first_v == 0) first_v = c;
            end
            exp_busy = (c <= exp_valid) && (rst_at == 0 || c <= rst_at);
            if (s_busy[0] !== exp_busy) busy_bad++;
            start[unit] = (c == pulse_at);
            if (rst_at != 0 && c == rst_at) begin
                rst = 1'b1;
                #1;
                check({tag, "_rst_min"},   s_min,   32'd1023);
                check({tag, "_rst_cnt"},   s_cnt,   32'd0);
                check({tag, "_rst_busy"},  s_busy,  32'd0);
                check({tag, "_rst_valid"}, s_valid, 32'd0);
                check({tag, "_rst_w"},     s_w,     32'd0);
            end
            if (rst_at != 0 && c == rst_at + 2) rst = 1'b0;
        end
        start[unit] = 1'b0;
        mode        = 1'b0;
        check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
        if (rst_at == 0) begin
            check({tag, "_valid_cycle"}, 32'(first_v), 32'(exp_valid));
            check({tag, "_valid_pulses"}, 32'(nv), 32'd1);
        end else begin
            check({tag, "_no_valid"}, 32'(nv), 32'd0);
        end
        check({tag, "_min"}, s_min, exp_min);
        check({tag, "_cnt"}, s_cnt, exp_cnt);
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        mode  = 1'b0;
        sel   = 0;
        repeat (2) @(negedge clk);
        check("reset_min",   s_min,   32'd1023);
        check("reset_cnt",   s_cnt,   32'd0);
        check("reset_busy",  s_busy,  32'd0);
        check("reset_valid", s_valid, 32'd0);
        check("reset_w",     s_w,     32'd0);
        check("reset_j",     s_j,     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", s_busy, 32'd0);

        // Diagonal-zero table: identity is the unique minimum.
        run("n4_min", 0, 1'b0, 121, 0, 0, 32'd0, 32'd1);
        // Maximum 40 reached by the 9 derangements of 4.
        run("n4_max", 0, 1'b1, 121, 0, 0, 32'd40, 32'd9);
        repeat (5) @(negedge clk);
        check("n4_hold_min", s_min, 32'd40);
        check("n4_hold_cnt", s_cnt, 32'd9);

        // Cost = J: every permutation sums to 0+1+2 = 3.
        run("n3_costj", 1, 1'b0, 25, 0, 0, 32'd3, 32'd6);
        check("n3_wj_c1", 32'(wj_log[1]), 32'h00);  // (0,0)
        check("n3_wj_c2", 32'(wj_log[2]), 32'h09);  // (1,1)
        check("n3_wj_c3", 32'(wj_log[3]), 32'h12);  // (2,2)
        check("n3_wj_c4", 32'(wj_log[4]), 32'h12);  // UPD holds (2,2)
        check("n3_wj_c5", 32'(wj_log[5]), 32'h00);  // (0,0)
        check("n3_wj_c6", 32'(wj_log[6]), 32'h0A);  // (1,2)
        check("n3_wj_c7", 32'(wj_log[7]), 32'h11);  // (2,1)

        // Constant maximum cost: 6*127 = 762 < 1023, all 720 tie.
        run("n6_const", 2, 1'b0, 5041, 0, 0, 32'd762, 32'd720);

        // Start re-pulsed mid-run is ignored.
        run("n4_repulse", 0, 1'b0, 121, 50, 0, 32'd0, 32'd1);

        // Mid-run reset aborts without a result, then a fresh run completes.
        run("n4_abort", 0, 1'b0, 121, 0, 60, 32'd1023, 32'd0);
        run("n4_after_rst", 0, 1'b0, 121, 0, 0, 32'd0, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised job-assignment solver.
- Enumerates every permutation of N jobs over N workers in lexicographic order.
- For each permutation, reads the cost of every worker/job pair through an external cost ROM port and accumulates the total.
- Reports the best (minimum or maximum, selected at start) total cost and the number of permutations that reach it. Adds a Start/Busy handshake, a selectable objective, and a configurable size and widths.

Parameters:
- N, 8, number of workers/jobs; legal range 2..8.
- IW, 3, index width of W/J; must satisfy 2^IW >= N.
- CW, 7, width of one Cost entry.
- SW, 10, width of the accumulated sum and of MinCost; must satisfy SW >= CW + IW.
- MW, 16, width of MatchCount; must hold N! (40320 for N=8).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous active-high reset.
- Start  in  1  run request; sampled only in IDLE.
- Mode  in  1  objective select: 0 = minimise, 1 = maximise; captured when Start is accepted.
- Cost  in  CW  cost of (W,J); combinational from the ROM; sampled at the rising edge ending the cycle in which W/J are driven.
- W  out  IW  worker index.
- J  out  IW  job index; equals perm[W].
- Busy  out  1  high from the cycle after Start is accepted through the Valid cycle.
- MinCost  out  SW  best total found (minimum or maximum, per Mode).
- MatchCount  out  MW  number of permutations whose total equals MinCost.
- Valid  out  1  one-cycle pulse when the results are final.

Behaviour:
- Reset values:
  - state = IDLE.
  - W = 0, J = 0.
  - Busy = 0, Valid = 0.
  - MinCost = all-ones, MatchCount = 0.
  - perm = identity (perm[i] = i).
- States: IDLE, EVAL, UPD, DONE.
- IDLE:
  - W = 0 and J = 0 are driven.
  - Start=1 at an edge latches Mode, sets perm = identity, clears sum/idx/MatchCount, sets MinCost = all-ones, and moves to EVAL.
- EVAL (N cycles):
  - Cycle k drives W = k, J = perm[k].
  - The edge ending cycle k adds Cost, zero-extended to SW, into sum.
  - After k = N-1, move to UPD.
- UPD (1 cycle): W and J hold their last values. At its edge:
  - First permutation of the run: MinCost = sum, MatchCount = 1.
  - Mode 0, sum < MinCost: MinCost = sum, MatchCount = 1.
  - Mode 1, sum > MinCost: MinCost = sum, MatchCount = 1.
  - sum == MinCost: MatchCount + 1, saturating at all-ones.
  - Otherwise: MinCost and MatchCount hold.
  - In the same edge:
    - sum is cleared.
    - perm advances to its lexicographic successor, computed combinationally: the rightmost i with perm[i] < perm[i+1]; swap perm[i] with the rightmost larger element; reverse the suffix after i.
  - If perm was the last permutation (N-1..0), go to DONE; else go to EVAL.
- DONE (1 cycle): Valid = 1, Busy = 1; next state is IDLE.
- Results:
  - MinCost and MatchCount hold after DONE until the next accepted Start.
  - Intermediate values are visible while Busy but are meaningful only at Valid.
- Latency: for a Start sampled at edge 0, Valid is high during cycle N!*(N+1)+1; Busy falls at the following edge.
- Start while not in IDLE is ignored. Mode changes while Busy are ignored.
- Start high continuously re-launches a run the cycle after DONE.
- RST at any time, including mid-run, returns all state and outputs to reset values asynchronously. No partial result is reported.
- Arithmetic: unsigned throughout. With the SW rule above, sum cannot overflow.

Test Plan:
- N=4, Cost = 0 when W==J else 10, Mode=0 -> MinCost=0, MatchCount=1; Valid high exactly in cycle 4!*5+1 = 121 after the Start edge, for one cycle.
- Same cost table, Mode=1 -> MinCost=40, MatchCount=9 (the derangements of 4).
- N=3, Cost = J -> every permutation sums to 3 -> MinCost=3, MatchCount=6. Check that the W/J sequence for the first two permutations is (0,0)(1,1)(2,2) then (0,0)(1,2)(2,1).
- N=8, Cost constant 127, Mode=0 -> MinCost=1016, MatchCount=40320, no overflow; Valid high in cycle 362881.
- Start pulsed again at cycle 50 of an N=4 run -> ignored; results and Valid timing are identical to the first scenario.
- RST asserted mid-run (N=4, cycle 60) -> MinCost=all-ones (1023 at SW=10), MatchCount=0, Busy=0, no Valid. A fresh Start then yields the first scenario's results.
